// File: rtl/ysyx_22050598_wb_arbiter.sv
// Merges EXU/LSU results onto the single register-file write port with round-robin
// arbitration (one registered write per cycle) and keeps a busy scoreboard for RAW/WAW issue stalls.
module ysyx_22050598_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_rd,
    input  logic [63:0] exu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    input  logic        iss_valid,
    input  logic        iss_wen,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    output logic        iss_stall,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [31:0] busy_vec
);

    typedef enum logic {
        PRIO_EXU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    prio_e       prio_q, prio_d;
    logic        exu_gnt, lsu_gnt;
    logic        rf_wen_q, rf_wen_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [63:0] rf_wdata_q, rf_wdata_d;
    logic [31:0] busy_q, busy_d;
    logic        iss_fire;

    // Grants depend only on valids and prio; nothing is granted while in reset.
    always_comb begin
        exu_gnt = !rst && exu_valid && (!lsu_valid || (prio_q == PRIO_EXU));
        lsu_gnt = !rst && lsu_valid && (!exu_valid || (prio_q == PRIO_LSU));
        prio_d  = prio_q;
        if (exu_gnt) begin
            prio_d = PRIO_LSU;
        end else if (lsu_gnt) begin
            prio_d = PRIO_EXU;
        end
    end

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (exu_gnt) begin
            rf_wen_d   = (exu_rd != 5'd0);
            rf_waddr_d = exu_rd;
            rf_wdata_d = exu_data;
        end else if (lsu_gnt) begin
            rf_wen_d   = (lsu_rd != 5'd0);
            rf_waddr_d = lsu_rd;
            rf_wdata_d = lsu_data;
        end
    end

    // Clear happens first so that a forced same-register set on this edge wins.
    always_comb begin
        iss_stall = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] ||
                                  (iss_wen && busy_q[iss_rd]));
        iss_fire  = iss_valid && iss_wen && !iss_stall && (iss_rd != 5'd0);
        busy_d    = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= PRIO_LSU;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 64'd0;
            busy_q     <= 32'd0;
        end else begin
            prio_q     <= prio_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    // A held write is dropped immediately when reset arrives mid-operation.
    assign rf_wen    = rf_wen_q && !rst;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_vec  = busy_q;
    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;

endmodule

// File: tb/tb_ysyx_22050598_wb_arbiter.sv
// Directed bench for the write-back arbiter: reset, single write, contention,
// scoreboard RAW/WAW/x0 and reset in the middle of a write.
module tb_ysyx_22050598_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        iss_valid, iss_wen, iss_stall;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

    ysyx_22050598_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_wen   (iss_wen),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_stall (iss_stall),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 64'hE000_0000_0000_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'hA000_0000_0000_0003;
        iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;

        // Reset held two cycles with both sources valid
        tick(); settle();
        chk("rst_exu_ready", {63'd0, exu_ready}, 64'd0);
        chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        chk("rst_rf_wen",    {63'd0, rf_wen},    64'd0);
        chk("rst_busy",      {32'd0, busy_vec},  64'd0);
        chk("rst_waddr",     {59'd0, rf_waddr},  64'd0);
        chk("rst_wdata",     rf_wdata,           64'd0);
        tick();
        rst = 1'b0;
        settle();

        // Contention: LSU, EXU, LSU, EXU -> waddr 3, 1, 4, 2
        chk("cont0_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        chk("cont0_exu_ready", {63'd0, exu_ready}, 64'd0);
        tick();
        lsu_rd = 5'd4; lsu_data = 64'hA000_0000_0000_0004;
        settle();
        chk("cont1_waddr", {59'd0, rf_waddr}, 64'd3);
        chk("cont1_wdata", rf_wdata, 64'hA000_0000_0000_0003);
        chk("cont1_wen",   {63'd0, rf_wen}, 64'd1);
        chk("cont1_exu_ready", {63'd0, exu_ready}, 64'd1);
        chk("cont1_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        tick();
        exu_rd = 5'd2; exu_data = 64'hE000_0000_0000_0002;
        settle();
        chk("cont2_waddr", {59'd0, rf_waddr}, 64'd1);
        chk("cont2_wdata", rf_wdata, 64'hE000_0000_0000_0001);
        chk("cont2_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        chk("cont2_exu_ready", {63'd0, exu_ready}, 64'd0);
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("cont3_waddr", {59'd0, rf_waddr}, 64'd4);
        chk("cont3_exu_ready", {63'd0, exu_ready}, 64'd1);
        tick();
        exu_valid = 1'b0;
        settle();
        chk("cont4_waddr", {59'd0, rf_waddr}, 64'd2);
        chk("cont4_wen",   {63'd0, rf_wen}, 64'd1);
        tick();
        chk("cont5_wen_idle", {63'd0, rf_wen}, 64'd0);

        // Single EXU write
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'hDEAD_BEEF_0000_0001;
        settle();
        chk("single_exu_ready", {63'd0, exu_ready}, 64'd1);
        tick();
        exu_valid = 1'b0;
        settle();
        chk("single_wen",   {63'd0, rf_wen}, 64'd1);
        chk("single_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("single_wdata", rf_wdata, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("single_wen_off",     {63'd0, rf_wen}, 64'd0);
        chk("single_waddr_hold",  {59'd0, rf_waddr}, 64'd5);

        // RAW: issue rd=7, then a consumer of x7
        iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd7;
        settle();
        chk("raw_issue_nostall", {63'd0, iss_stall}, 64'd0);
        tick();
        iss_wen = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd7;
        settle();
        chk("raw_busy_set", {32'd0, busy_vec}, 64'h80);
        chk("raw_stall",    {63'd0, iss_stall}, 64'd1);
        // WAW on busy x7
        iss_wen = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0;
        settle();
        chk("waw_stall", {63'd0, iss_stall}, 64'd1);
        // Writing x0 never sets a busy bit
        iss_rd = 5'd0;
        settle();
        chk("x0_issue_nostall", {63'd0, iss_stall}, 64'd0);
        tick();
        chk("x0_busy_unchanged", {32'd0, busy_vec}, 64'h80);
        // Dependent waits; LSU returns x7
        iss_wen = 1'b0; iss_rs1 = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h0000_0000_0000_0777;
        settle();
        chk("raw_lsu_ready",   {63'd0, lsu_ready}, 64'd1);
        chk("raw_stall_t",     {63'd0, iss_stall}, 64'd1);
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("raw_t1_wen",   {63'd0, rf_wen}, 64'd1);
        chk("raw_t1_waddr", {59'd0, rf_waddr}, 64'd7);
        chk("raw_t1_stall", {63'd0, iss_stall}, 64'd1);
        chk("raw_t1_busy",  {32'd0, busy_vec}, 64'h80);
        tick();
        chk("raw_t2_stall", {63'd0, iss_stall}, 64'd0);
        chk("raw_t2_busy",  {32'd0, busy_vec}, 64'd0);
        iss_valid = 1'b0; iss_rs1 = 5'd0;

        // EXU write to x0: accepted, no rf_wen
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'h1234;
        settle();
        chk("x0_exu_ready", {63'd0, exu_ready}, 64'd1);
        tick();
        exu_valid = 1'b0;
        settle();
        chk("x0_rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("x0_waddr",  {59'd0, rf_waddr}, 64'd0);

        // Reset mid-write: LSU grant with x9 busy, reset next cycle
        iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h99;
        settle();
        chk("rmw_busy9",     {32'd0, busy_vec}, 64'h200);
        chk("rmw_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        tick();
        rst = 1'b1; exu_valid = 1'b1; exu_rd = 5'd1; lsu_rd = 5'd3;
        settle();
        chk("rmw_t1_wen",       {63'd0, rf_wen}, 64'd0);
        chk("rmw_t1_exu_ready", {63'd0, exu_ready}, 64'd0);
        chk("rmw_t1_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("rmw_t2_wen",       {63'd0, rf_wen}, 64'd0);
        chk("rmw_t2_busy",      {32'd0, busy_vec}, 64'd0);
        chk("rmw_t2_lsu_first", {63'd0, lsu_ready}, 64'd1);
        chk("rmw_t2_exu_wait",  {63'd0, exu_ready}, 64'd0);
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050598_wb_arbiter.md
# ysyx_22050598_wb_arbiter

Write-back arbiter and register scoreboard for the 64-bit integer register file. It merges results from the EXU and the LSU onto the register file's single write port, registering one write per cycle. It also tracks which architectural registers have a result still in flight, and stalls issue on RAW and WAW hazards. It sits between the EXU/LSU result paths and the register file write port (`wen`/`waddr`/`wdata`), beside the issue stage.

## Interface
Parameters:
- none; XLEN is fixed at 64 and the register count at 32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted this cycle
- exu_rd  in  5  EXU destination register
- exu_data  in  64  EXU result
- lsu_valid  in  1  LSU load result valid
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_rd  in  5  LSU destination register
- lsu_data  in  64  LSU load data
- iss_valid  in  1  issue stage presents an instruction
- iss_wen  in  1  issuing instruction writes rd
- iss_rd  in  5  issuing destination
- iss_rs1, iss_rs2  in  5 each  issuing sources
- iss_stall  out  1  hazard: issue must hold
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  64  register file write data
- busy_vec  out  32  scoreboard state, bit i = register i pending; bit 0 is always 0

## Operation
- Handshake: each source holds valid, rd and data stable until its ready is high in the same cycle. A transfer occurs when valid && ready.
- Readies are combinational from the valids and the priority pointer `prio` (0 = EXU, 1 = LSU). At most one ready is high per cycle.
  - Only one source valid: that source is granted.
  - Both valid: the source named by `prio` is granted.
  - Neither valid: no grant.
- `prio` update: after any grant, `prio` points to the non-granted source. With no grant, `prio` holds. This guarantees neither source waits more than one contended cycle.
- Output register: on a grant, the next edge loads rf_waddr = rd and rf_wdata = data. rf_wen loads (rd != 0), so a write to x0 is accepted but never asserts rf_wen. With no grant, rf_wen loads 0 and addr/data hold.
- Scoreboard set: busy[iss_rd] is set at the edge when all of the following hold: iss_valid, iss_wen, !iss_stall, iss_rd != 0.
- Scoreboard clear: busy[rf_waddr] is cleared at the edge where rf_wen is high. This is the same edge at which the register file commits the data.
- Same-register set and clear on one edge cannot occur, because an issue to a busy rd stalls. If it is forced anyway, set wins.
- iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || (iss_wen && busy[iss_rd])). It is purely combinational from registered busy. Register 0 is never busy.
- Results whose rd is not marked busy are still written; the scoreboard bit simply stays 0.

## Timing
- Reset values: prio = 1 (LSU first on first contention), busy_vec = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
- exu_ready and lsu_ready are 0 during any cycle in which rst is high.
- Latency: transfer in cycle t gives rf_wen = 1 in cycle t+1. The register file commits at the end of t+1, and busy clears at that same edge. A dependent instruction sees iss_stall = 0 in cycle t+2 and reads the new value.
- Throughput: one write-back per cycle. Back-to-back grants to the same source are allowed when the other source is idle.
- Reset mid-operation: a write held in the output register is dropped (rf_wen forced to 0), all busy bits clear, prio returns to 1. Sources re-present after reset.
- No combinational path from rf_* to any input. Ready depends only on valids and prio.

## Test plan
- Reset: assert rst for 2 cycles with exu_valid = lsu_valid = 1 → both readies 0, rf_wen = 0, busy_vec = 0; first cycle after reset grants LSU.
- Single EXU write: exu_valid = 1, rd = 5, data = 0xDEAD_BEEF_0000_0001 in cycle t → exu_ready = 1 at t; rf_wen = 1, rf_waddr = 5, rf_wdata = that value at t+1; rf_wen = 0 at t+2.
- Contention: both valid for 4 cycles with distinct rds (EXU rd 1–2, LSU rd 3–4, each source advancing on grant) → grants alternate LSU, EXU, LSU, EXU; rf_waddr sequence 3, 1, 4, 2.
- Scoreboard RAW: issue rd = 7 with iss_wen; next instruction rs1 = 7 → iss_stall = 1 until LSU returns rd 7. Stall drops exactly two cycles after the LSU transfer cycle; busy_vec[7] is 1 during the stall and 0 afterwards.
- WAW and x0: issue with iss_wen and rd = 7 while busy[7] = 1 → stall. Issue with iss_wen and rd = 0 → busy_vec unchanged. EXU write to rd = 0 → exu_ready = 1, rf_wen stays 0.
- Reset mid-write: grant in cycle t, rst high in t+1 → rf_wen = 0 in t+1 and t+2; busy_vec = 0 after.
